// File: rtl/chime_seq.sv
// Beep-sequence generator: N square-wave tone bursts separated by silent gaps,
// with start/busy/done handshake, abort and mute. Optional macro: CHIME_LONG_LAST_EN.
module chime_seq #(
  parameter int CNT_W     = 4,
  parameter int TONE_HALF = 25000,
  parameter int ON_CYC    = 10000000,
  parameter int OFF_CYC   = 20000000,
  parameter int LONG_CYC  = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             enable,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] beep_idx,
  output logic             buzz_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int ON_OFF_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
`ifdef CHIME_LONG_LAST_EN
  localparam int CYC_MAX = (LONG_CYC > ON_OFF_MAX) ? LONG_CYC : ON_OFF_MAX;
`else
  localparam int CYC_MAX = ON_OFF_MAX;
`endif
  localparam int CYC_W  = $clog2(CYC_MAX + 1);
  localparam int TONE_W = $clog2(TONE_HALF + 1);

  localparam logic [CYC_W-1:0]  ON_LAST   = CYC_W'(ON_CYC - 1);
  localparam logic [CYC_W-1:0]  OFF_LAST  = CYC_W'(OFF_CYC - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
`ifdef CHIME_LONG_LAST_EN
  localparam logic [CYC_W-1:0]  LONG_LAST = CYC_W'(LONG_CYC - 1);
`endif

  if (TONE_HALF < 1 || ON_CYC < 1 || OFF_CYC < 1 || LONG_CYC < 1) begin : g_param_chk
    $error("chime_seq: TONE_HALF, ON_CYC, OFF_CYC and LONG_CYC must all be >= 1");
  end

  logic [1:0]        state, state_n;
  logic [CNT_W-1:0]  remaining, remaining_n;
  logic [CYC_W-1:0]  cyc_cnt, cyc_n;
  logic [TONE_W-1:0] tone_cnt, tone_n;
  logic              phase, phase_n;
  logic [CNT_W-1:0]  idx_n;
  logic [CYC_W-1:0]  beep_last;

  // Only the final beep of a sequence may use the long length.
`ifdef CHIME_LONG_LAST_EN
  assign beep_last = (remaining == CNT_W'(1)) ? LONG_LAST : ON_LAST;
`else
  assign beep_last = ON_LAST;
`endif

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    cyc_n       = cyc_cnt;
    tone_n      = tone_cnt;
    phase_n     = phase;
    idx_n       = beep_idx;
    case (state)
      S_IDLE: begin
        // Counters and tone phase are primed here so ON entry starts a fresh beep.
        idx_n   = '0;
        cyc_n   = '0;
        tone_n  = '0;
        phase_n = 1'b1;
        if (start && !abort) begin
          if (count != '0) begin
            state_n     = S_ON;
            remaining_n = count;
            idx_n       = CNT_W'(1);
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_ON: begin
        if (abort) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else if (cyc_cnt == beep_last) begin
          cyc_n = '0;
          if (remaining > CNT_W'(1)) begin
            state_n     = S_OFF;
            remaining_n = remaining - CNT_W'(1);
          end else begin
            state_n = S_DONE;
            idx_n   = '0;
          end
        end else begin
          cyc_n = cyc_cnt + CYC_W'(1);
          if (tone_cnt == TONE_LAST) begin
            tone_n  = '0;
            phase_n = ~phase;
          end else begin
            tone_n = tone_cnt + TONE_W'(1);
          end
        end
      end
      S_OFF: begin
        if (abort) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else if (cyc_cnt == OFF_LAST) begin
          state_n = S_ON;
          cyc_n   = '0;
          tone_n  = '0;
          phase_n = 1'b1;
          idx_n   = beep_idx + CNT_W'(1);
        end else begin
          cyc_n = cyc_cnt + CYC_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      beep_idx <= '0;
      buzz_out <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= (state_n == S_ON) || (state_n == S_OFF);
      done     <= (state_n == S_DONE);
      beep_idx <= idx_n;
      buzz_out <= (state_n == S_ON) && phase_n && enable;
    end
  end

  // Datapath counters need no reset: IDLE reloads them before any use.
  always_ff @(posedge clk) begin
    remaining <= remaining_n;
    cyc_cnt   <= cyc_n;
    tone_cnt  <= tone_n;
    phase     <= phase_n;
  end

endmodule

// File: doc/chime_seq.md
Name: chime_seq

Overview:
- Parametrised successor to the fixed count-driven buzzer: on a start pulse it emits N beeps, where N is latched from `count`.
- Each beep is a square-wave tone burst of programmable length, separated by programmable silent gaps.
- Provides a start/busy/done handshake, abort, mute and a current-beep index.
- Sits between the clock/alarm control logic (hourly chime, alarm, key-click) and the board buzzer pin.

Parameters:
- CNT_W, 4, width of `count` and `beep_idx`; max beeps = 2^CNT_W-1.
- TONE_HALF, 25000, clk cycles per tone half-period (2 kHz at 100 MHz); must be >=1.
- ON_CYC, 10000000, clk cycles per beep (tone burst); must be >=1.
- OFF_CYC, 20000000, clk cycles of silence between beeps; must be >=1.
- LONG_CYC, 50000000, final-beep length in cycles; used only when CHIME_LONG_LAST_EN is defined.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset: synchronous, active-high.
- start, input, 1, request pulse; sampled only in IDLE.
- count, input, CNT_W, number of beeps; latched on accepted start.
- enable, input, 1, mute control: 0 forces buzz_out low; timing still runs.
- abort, input, 1, synchronous cancel of a running sequence.
- busy, output, 1, high while beeping or in a gap.
- done, output, 1, one-cycle pulse on normal completion.
- beep_idx, output, CNT_W, current beep number (1-based); 0 when not busy.
- buzz_out, output, 1, tone drive to buzzer.

Behaviour:
- One clock, one FSM: IDLE, ON, OFF, DONE. All outputs are registered.
- Reset (rst=1 at a clk edge) beats every other input. It forces IDLE, and busy=0, done=0, beep_idx=0, buzz_out=0 from the next cycle. Reset mid-sequence is a clean abort with no done pulse.
- IDLE, start=1, count!=0, abort=0:
  - latch count into `remaining`;
  - go to ON next cycle; busy=1, beep_idx=1.
- IDLE, start=1, count==0: go to DONE. No beep is produced and busy never rises.
- IDLE, start=1, abort=1: abort wins; stay in IDLE.
- start while busy: ignored. Changes to count after acceptance have no effect.
- ON:
  - a cycle counter runs 0..len-1, where len=ON_CYC (or LONG_CYC, see Optional Feature);
  - the tone phase restarts at every beep: buzz_out=enable on the first ON cycle and toggles every TONE_HALF cycles;
  - on the last ON cycle: if remaining>1, decrement remaining and go to OFF; else go to DONE.
- OFF:
  - buzz_out=0 for OFF_CYC cycles, then go to ON;
  - beep_idx increments on OFF->ON.
- DONE: lasts one cycle with done=1, busy=0, beep_idx=0, buzz_out=0, then returns to IDLE. A start arriving in the DONE cycle is ignored.
- abort=1 in ON, OFF or DONE: go to IDLE at the next edge. All outputs are 0 the following cycle, and no done pulse is produced.
- enable=0: buzz_out reads 0 but all counters keep running. If enable is raised mid-beep, the tone resumes at its current phase.
- Counter widths are $clog2(max(ON_CYC, LONG_CYC, OFF_CYC)+1) and $clog2(TONE_HALF+1). Counters do not wrap during a state; they are cleared on every state entry.
- Total busy cycles for N beeps = N*ON_CYC + (N-1)*OFF_CYC. done asserts in the cycle immediately after the last busy cycle.

Optional Feature:
- Macro: CHIME_LONG_LAST_EN.
- Defined: the final beep of every sequence lasts LONG_CYC cycles instead of ON_CYC, giving a time-signal style long last pip. With count==1 the single beep is long.
- Undefined: all beeps last ON_CYC; LONG_CYC is unused and no extra counter width is synthesised for it.

Test Plan:
Common setup: TONE_HALF=2, ON_CYC=8, OFF_CYC=4, CNT_W=4, macro undefined unless stated; start at cycle 0.
- count=3, enable=1 -> busy high cycles 1..32; per beep buzz_out follows 1,1,0,0,1,1,0,0; buzz_out 0 in the gaps; beep_idx steps 1->2->3; done=1 only in cycle 33.
- count=0 -> done=1 in cycle 1; busy and buzz_out stay 0.
- count=3, abort at cycle 10 (first gap) -> busy, beep_idx and buzz_out all 0 from cycle 11; no done; a new start at cycle 15 runs normally.
- count=2 with enable=0 throughout -> buzz_out always 0; busy cycles 1..20; done in cycle 21.
- count=2, second start with count=5 at cycle 4 -> ignored; exactly 2 beeps; done in cycle 21. Also rst at cycle 5 on a fresh run -> all outputs 0 from cycle 6.
- CHIME_LONG_LAST_EN defined, LONG_CYC=16, count=2 -> beep 1 is 8 cycles, gap 4, beep 2 is 16 cycles (buzz_out pattern repeated 4 times); busy cycles 1..28; done in cycle 29.
